// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding-mux selects and FSM states.
// HAZARD_MD_INTERLOCK_EN adds the MD_BUSY state for the multiply/divide interlock.
package hazard_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_RSVD  = 2'b11;

`ifdef HAZARD_MD_INTERLOCK_EN
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      LOAD_STALL = 2'b01,
      MD_BUSY    = 2'b10
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      LOAD_STALL = 2'b01
   } state_t;
`endif

   // The EX/MEM producer is younger than MEM/WB, so its match takes priority.
   function automatic logic [1:0] fwd_select(input logic ex_hit, input logic mem_hit);
      if (ex_hit)
         return FWD_EXMEM;
      else if (mem_hit)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_md_busy_ctr.sv
// Multiply/divide occupancy counter: loads the latency, counts down to zero and
// holds there, flagging zero.
module md_busy_ctr #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (!zero)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: registered forwarding selects, load-use and branch
// stall/flush control. HAZARD_MD_INTERLOCK_EN adds the mult/div busy interlock.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rd,
   input  logic       ex_regwrite,
   input  logic       ex_memread,
   input  logic [4:0] mem_rd,
   input  logic       mem_regwrite,
   input  logic       id_is_md,
   input  logic       id_reads_hilo,
   input  logic       ex_branch_taken,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       md_busy
);

   state_t state, state_next;
   logic   load_use, load_use_stall, md_stall, stall;
   logic   ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b;

   assign ex_hit_a  = ex_regwrite  && (ex_rd  == id_rs) && (id_rs != 5'd0) && id_uses_rs;
   assign mem_hit_a = mem_regwrite && (mem_rd == id_rs) && (id_rs != 5'd0);
   assign ex_hit_b  = ex_regwrite  && (ex_rd  == id_rt) && (id_rt != 5'd0) && id_uses_rt;
   assign mem_hit_b = mem_regwrite && (mem_rd == id_rt) && (id_rt != 5'd0);

   // A load in EX cannot forward in time; a branch redirect kills the consumer anyway.
   assign load_use = ex_memread && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
   assign load_use_stall = load_use && !ex_branch_taken && (state != LOAD_STALL);

`ifdef HAZARD_MD_INTERLOCK_EN
   logic [CNT_W-1:0] md_count;
   logic             md_zero, md_accept, md_busy_next;

   assign md_stall     = !md_zero && (id_is_md || id_reads_hilo) && !ex_branch_taken;
   assign md_accept    = id_is_md && !stall && !ex_branch_taken;
   assign md_busy_next = md_accept || (md_count > CNT_W'(1));
   assign md_busy      = !md_zero;

   md_busy_ctr #(.CNT_W(CNT_W)) u_md_busy_ctr (
      .clk      (clk),
      .rstn     (rstn),
      .load     (md_accept),
      .load_val (CNT_W'(MD_LAT)),
      .count    (md_count),
      .zero     (md_zero)
   );
`else
   logic             unused_md_inputs;
   logic [CNT_W-1:0] unused_md_lat;

   assign unused_md_inputs = id_is_md ^ id_reads_hilo;
   assign unused_md_lat    = CNT_W'(MD_LAT);
   assign md_stall         = 1'b0;
   assign md_busy          = 1'b0;
`endif

   // Outputs are forced quiet while reset is held, even with live ID/EX inputs.
   assign stall      = (load_use_stall || md_stall) && rstn;
   assign pc_stall   = stall;
   assign ifid_stall = stall;
   assign ifid_flush = ex_branch_taken && rstn;
   assign idex_flush = (stall || ex_branch_taken) && rstn;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      if (load_use_stall)
         state_next = LOAD_STALL;
`ifdef HAZARD_MD_INTERLOCK_EN
      else if (md_busy_next)
         state_next = MD_BUSY;
`endif
   end

   // A bubble inserted into EX must not carry a forwarding select with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (idex_flush) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else begin
         fwd_a_sel <= fwd_select(ex_hit_a, mem_hit_a);
         fwd_b_sel <= fwd_select(ex_hit_b, mem_hit_b);
      end
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter MD_LAT, default 32: multiply/divide busy cycles.
REQ-003 Parameter CNT_W, default $clog2(MD_LAT+1): busy-counter width.
REQ-004 Port clk  in  1  pipeline clock.
REQ-005 Port rstn  in  1  asynchronous active-low reset.
REQ-006 Ports id_rs, id_rt  in  5 each  ID-stage source registers; id_uses_rs, id_uses_rt  in  1 each  source-valid flags.
REQ-007 Ports ex_rd  in  5; ex_regwrite, ex_memread  in  1  EX-stage producer.
REQ-008 Ports mem_rd  in  5; mem_regwrite  in  1  MEM-stage producer.
REQ-009 Ports id_is_md, id_reads_hilo  in  1  ID holds mult/div, or mfhi/mflo.
REQ-010 Port ex_branch_taken  in  1  redirect resolved in EX.
REQ-011 Ports fwd_a_sel, fwd_b_sel  out  2  registered EX-operand MUX4 selects.
REQ-012 Ports pc_stall, ifid_stall, ifid_flush, idex_flush  out  1  pipeline-register controls.
REQ-013 Port md_busy  out  1  multiply/divide unit occupied.

Function
REQ-014 Select encoding: 00 register-file value, 01 MEM/WB write data, 10 EX/MEM ALU result, 11 reserved and never driven.
REQ-015 Selects are computed in ID and registered, so they align with the instruction in EX one cycle later.
REQ-016 fwd_a_sel: 10 if ex_regwrite, ex_rd==id_rs, id_rs!=0, id_uses_rs. Otherwise 01 if mem_regwrite, mem_rd==id_rs, id_rs!=0. Otherwise 00. The EX match wins.
REQ-017 fwd_b_sel uses the same rule on id_rt and id_uses_rt.
REQ-018 The register file is write-through, so a WB-stage producer seen in ID needs no select.
REQ-019 Load-use: ex_memread, ex_rd!=0 and ex_rd matches a used ID source SHALL assert pc_stall, ifid_stall and idex_flush for exactly one cycle (state LOAD_STALL).
REQ-020 The next-cycle select for that load is 01.
REQ-021 FSM states: IDLE, LOAD_STALL, MD_BUSY.
- IDLE to LOAD_STALL on load-use.
- LOAD_STALL to IDLE after one cycle.
- IDLE to MD_BUSY on accepted id_is_md.
- MD_BUSY to IDLE when the counter reaches 0.
REQ-022 Accepted id_is_md means: not stalled and not flushed that cycle. It loads the counter with MD_LAT, which decrements every cycle to 0.
REQ-023 In MD_BUSY, id_is_md or id_reads_hilo SHALL stall and flush exactly as a load-use does, until the cycle the counter reads 0.
REQ-024 md_busy = counter != 0.
REQ-025 ex_branch_taken SHALL assert ifid_flush and idex_flush and SHALL override stall outputs in the same cycle. The flushed ID instruction SHALL NOT start mult/div or cause a stall.
REQ-026 Whenever idex_flush is asserted, the registered selects SHALL load 00.
REQ-027 Load-use and busy-stall occurring together SHALL produce a single merged stall. The counter keeps decrementing during any stall.

Reset
REQ-028 While rstn is low: fwd_a_sel=fwd_b_sel=00, all stall/flush outputs 0, counter 0, md_busy 0, state IDLE.
REQ-029 Reset asserted mid-stall or mid-busy SHALL abort immediately. The first edge after release operates from IDLE.

Configuration
REQ-030 Macro HAZARD_MD_INTERLOCK_EN: when defined, the MD_BUSY state, counter, md_busy and REQ-021..024 mult/div behaviour are compiled in.
REQ-031 When HAZARD_MD_INTERLOCK_EN is undefined:
- md_busy is tied 0.
- id_is_md and id_reads_hilo are ignored.
- The FSM has only IDLE and LOAD_STALL.

Structure
REQ-032 A shared package/header hazard_pkg SHALL hold:
- the constants FWD_RF, FWD_WB, FWD_EXMEM, FWD_RSVD;
- the FSM state encodings.
REQ-033 The busy counter SHALL be a sub-module md_busy_ctr (load, decrement, zero flag).

Verification
REQ-034 Pattern add $3 in EX, then sub $4,$3,$5 in ID -> next cycle fwd_a_sel=10, no stall.
REQ-035 Pattern lw $2 in EX, then add $6,$2,$2 in ID -> one cycle with pc_stall=ifid_stall=idex_flush=1 and selects 00; following cycle fwd_a_sel=fwd_b_sel=01.
REQ-036 Producers writing $0 in EX and MEM -> selects stay 00, no stall.
REQ-037 With the macro defined and MD_LAT=4: mult issued, then mflo one cycle later -> md_busy high 4 cycles; mflo stalls until the counter reads 0 and then proceeds.
REQ-038 Load-use with ex_branch_taken=1 in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0, state stays IDLE.
REQ-039 rstn pulsed low during MD_BUSY -> md_busy=0 at once; a mflo after release is not stalled.
